// File: rtl/maint_pkg.sv
// Shared definitions for the maintenance scheduler and maint_handler:
// default widths/limits and the request/ack bundles exchanged between them.
package maint_pkg;

    localparam int unsigned CNT_WIDTH = 28;
    localparam int unsigned MAX_DEBT  = 8;

    typedef struct packed {
        logic autoref;
        logic zq;
        logic pr_rd;
    } maint_req_t;

    typedef struct packed {
        logic autoref;
        logic zq;
    } maint_ack_t;

endpackage

// File: rtl/maint_interval_timer.sv
// Reloading down-counter: one-cycle tick every `period` cycles while enabled.
// A zero period, or en low, parks the counter at 0 so the next enable reloads it.
module maint_interval_timer
    import maint_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = maint_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] period,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 active;

    always_comb begin
        active = en && (period != '0);
        tick   = active && (cnt_q == CNT_WIDTH'(1));
        cnt_d  = cnt_q - CNT_WIDTH'(1);
        if (!active) begin
            cnt_d = '0;
        end else if (cnt_q <= CNT_WIDTH'(1)) begin
            // covers both expiry and a fresh load from the parked state
            cnt_d = period;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/maint_scheduler.sv
// Maintenance scheduler: refresh/ZQ/periodic-read timers turned into level requests.
// MAINT_SCHED_POSTPONE_EN: refresh debt may grow to MAX_DEBT; otherwise the limit is 1.
module maint_scheduler
    import maint_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = maint_pkg::CNT_WIDTH,
    parameter int unsigned MAX_DEBT  = maint_pkg::MAX_DEBT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_en,
    input  logic [CNT_WIDTH-1:0]           cfg_trefi,
    input  logic [CNT_WIDTH-1:0]           cfg_tzqi,
    input  logic [CNT_WIDTH-1:0]           cfg_tprd,
    input  logic                           iseq_busy,
    input  logic                           pr_rd_lock,
    output logic                           autoref_req,
    input  logic                           autoref_ack,
    output logic                           zq_req,
    input  logic                           zq_ack,
    output logic                           pr_rd_req,
    output logic [$clog2(MAX_DEBT+1)-1:0]  ref_debt,
    output logic                           maint_urgent,
    output logic                           debt_ovf
);

    localparam int unsigned DEBT_W = $clog2(MAX_DEBT + 1);

`ifdef MAINT_SCHED_POSTPONE_EN
    localparam logic [DEBT_W-1:0] DEBT_LIMIT = DEBT_W'(MAX_DEBT);
`else
    localparam logic [DEBT_W-1:0] DEBT_LIMIT = DEBT_W'(1);
`endif

    logic              ref_tick, zq_tick, prd_tick;
    maint_ack_t        ack;
    logic              ack_eff, lock_rise;

    logic [DEBT_W-1:0] debt_q, debt_d;
    logic              ovf_q, ovf_d;
    logic              zq_pend_q, zq_pend_d;
    logic              prd_pend_q, prd_pend_d;
    logic              lock_q, lock_d;
    logic              urgent_q, urgent_d;
    maint_req_t        req_q, req_d;

    maint_interval_timer #(.CNT_WIDTH(CNT_WIDTH)) u_trefi (
        .clk    (clk),
        .rst    (rst),
        .en     (cfg_en),
        .period (cfg_trefi),
        .tick   (ref_tick)
    );

    maint_interval_timer #(.CNT_WIDTH(CNT_WIDTH)) u_tzqi (
        .clk    (clk),
        .rst    (rst),
        .en     (cfg_en),
        .period (cfg_tzqi),
        .tick   (zq_tick)
    );

    maint_interval_timer #(.CNT_WIDTH(CNT_WIDTH)) u_tprd (
        .clk    (clk),
        .rst    (rst),
        .en     (cfg_en),
        .period (cfg_tprd),
        .tick   (prd_tick)
    );

    always_comb begin
        ack.autoref = autoref_ack;
        ack.zq      = zq_ack;
        ack_eff     = ack.autoref && (debt_q != '0);
        lock_rise   = pr_rd_lock && !lock_q;
        lock_d      = pr_rd_lock;

        debt_d      = debt_q;
        ovf_d       = ovf_q;
        if (ref_tick && !ack_eff) begin
            if (debt_q == DEBT_LIMIT) begin
                ovf_d = 1'b1;
            end else begin
                debt_d = debt_q + DEBT_W'(1);
            end
        end else if (!ref_tick && ack_eff) begin
            debt_d = debt_q - DEBT_W'(1);
        end

        zq_pend_d  = zq_tick || (zq_pend_q && !ack.zq);
        // ticks under the lock are dropped, not queued behind it
        prd_pend_d = !lock_rise && (prd_pend_q || (prd_tick && !pr_rd_lock));

        if (!cfg_en) begin
            debt_d     = '0;
            ovf_d      = 1'b0;
            zq_pend_d  = 1'b0;
            prd_pend_d = 1'b0;
        end

        urgent_d      = (debt_d == DEBT_LIMIT);
        req_d.autoref = (debt_d != '0) && (!iseq_busy || urgent_d);
        req_d.zq      = zq_pend_d && !iseq_busy && !urgent_d;
        req_d.pr_rd   = prd_pend_d && !pr_rd_lock && !iseq_busy && !urgent_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debt_q     <= '0;
            ovf_q      <= 1'b0;
            zq_pend_q  <= 1'b0;
            prd_pend_q <= 1'b0;
            lock_q     <= 1'b0;
            urgent_q   <= 1'b0;
            req_q      <= '0;
        end else begin
            debt_q     <= debt_d;
            ovf_q      <= ovf_d;
            zq_pend_q  <= zq_pend_d;
            prd_pend_q <= prd_pend_d;
            lock_q     <= lock_d;
            urgent_q   <= urgent_d;
            req_q      <= req_d;
        end
    end

    assign autoref_req  = req_q.autoref;
    assign zq_req       = req_q.zq;
    assign pr_rd_req    = req_q.pr_rd;
    assign ref_debt     = debt_q;
    assign maint_urgent = urgent_q;
    assign debt_ovf     = ovf_q;

endmodule

// File: tb/tb_maint_scheduler.sv
// Self-checking bench for maint_scheduler: vector table, directed corner
// sequences, and randomized traffic against a cycle-schedule reference model.
`timescale 1ns/1ps
module tb_maint_scheduler;

    localparam int CW = 28;
    localparam int MD = 8;
`ifdef MAINT_SCHED_POSTPONE_EN
    localparam int LIM = MD;
`else
    localparam int LIM = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_en;
    logic [CW-1:0] cfg_trefi, cfg_tzqi, cfg_tprd;
    logic          iseq_busy, pr_rd_lock, autoref_ack, zq_ack;
    logic          autoref_req, zq_req, pr_rd_req, maint_urgent, debt_ovf;
    logic [3:0]    ref_debt;

    maint_scheduler #(.CNT_WIDTH(CW), .MAX_DEBT(MD)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_en       (cfg_en),
        .cfg_trefi    (cfg_trefi),
        .cfg_tzqi     (cfg_tzqi),
        .cfg_tprd     (cfg_tprd),
        .iseq_busy    (iseq_busy),
        .pr_rd_lock   (pr_rd_lock),
        .autoref_req  (autoref_req),
        .autoref_ack  (autoref_ack),
        .zq_req       (zq_req),
        .zq_ack       (zq_ack),
        .pr_rd_req    (pr_rd_req),
        .ref_debt     (ref_debt),
        .maint_urgent (maint_urgent),
        .debt_ovf     (debt_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_en = 1'b0; cfg_trefi = '0; cfg_tzqi = '0; cfg_tprd = '0;
        iseq_busy = 1'b0; pr_rd_lock = 1'b0; autoref_ack = 1'b0; zq_ack = 1'b0;
        #12;
        rst = 1'b0;
        chk("reset_outs", {ref_debt, maint_urgent, debt_ovf, autoref_req, zq_req, pr_rd_req}, '0);
    endtask

    typedef struct {
        logic en;
        logic ack;
        int   debt;
        logic req;
    } vec_t;

    vec_t tbl[23];

    // reference-model state
    int P[3];
    bit act_t[3];
    int nt[3];
    bit tk[3];
    int m_debt;
    bit m_ovf, m_zq, m_prd, m_lock, m_urg, m_ar, m_zr, m_pr;

    initial begin
        int last_rise, first_rise, rises, max_debt, off, e;
        bit prev_req, ae;

        // ---------------- table: trefi=4, busy low ----------------
        tbl[0]  = '{1'b1, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 0, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 0, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 1, 1'b1};

        do_reset();
        cfg_trefi = CW'(4);
        for (int i = 0; i < 23; i++) begin
            cfg_en      = tbl[i].en;
            autoref_ack = tbl[i].ack;
            step();
            chk("tbl_debt",   ref_debt,     tbl[i].debt);
            chk("tbl_req",    autoref_req,  tbl[i].req);
            chk("tbl_urgent", maint_urgent, (tbl[i].debt == LIM) ? 1 : 0);
            chk("tbl_other",  {debt_ovf, zq_req, pr_rd_req}, 0);
        end
        autoref_ack = 1'b0;

        // ---------------- refresh period: trefi=100, ack 5 cycles after req ----------------
        do_reset();
        cfg_trefi = CW'(100);
        cfg_en = 1'b1;
        last_rise = 0; first_rise = 0; rises = 0; max_debt = 0; prev_req = 0;
        for (int ed = 1; ed <= 450; ed++) begin
            autoref_ack = (last_rise != 0) && (ed == last_rise + 5);
            step();
            if (int'(ref_debt) > max_debt) max_debt = int'(ref_debt);
            if (autoref_req && !prev_req) begin
                if (last_rise != 0) chk("ref_period", ed - last_rise, 100);
                else first_rise = ed;
                last_rise = ed;
                rises++;
            end
            prev_req = autoref_req;
        end
        autoref_ack = 1'b0;
        chk("ref_first_rise", first_rise, 101);
        chk("ref_rises", rises, 4);
        chk("ref_debt_max", max_debt, 1);

`ifdef MAINT_SCHED_POSTPONE_EN
        // ---------------- postponement, urgency, ovf, tick+ack, urgent masking ----------------
        do_reset();
        cfg_trefi = CW'(10);
        cfg_tzqi  = CW'(83);
        cfg_en    = 1'b1;
        for (int ed = 1; ed <= 112; ed++) begin
            iseq_busy   = (ed <= 81);
            autoref_ack = (ed == 87) || (ed >= 102 && ed <= 106) || (ed == 111);
            zq_ack      = (ed == 88);
            step();
            case (ed)
                71: begin
                    chk("post_debt7", ref_debt, 7);
                    chk("post_req_busy", autoref_req, 0);
                end
                81: begin
                    chk("post_debt8", ref_debt, 8);
                    chk("post_urgent", maint_urgent, 1);
                    chk("post_req_urgent", autoref_req, 1);
                    chk("post_no_ovf", debt_ovf, 0);
                end
                84, 85, 86: chk("zq_masked", zq_req, 0);
                87: begin
                    chk("zq_debt7", ref_debt, 7);
                    chk("zq_unurgent", maint_urgent, 0);
                    chk("zq_unmasked", zq_req, 1);
                    chk("zq_ref_req", autoref_req, 1);
                end
                88: chk("zq_acked", zq_req, 0);
                91: chk("post_urgent_again", maint_urgent, 1);
                101: begin
                    chk("ovf_set", debt_ovf, 1);
                    chk("ovf_debt", ref_debt, 8);
                end
                106: chk("debt_after_acks", ref_debt, 3);
                111: chk("tick_ack_same", ref_debt, 3);
                default: ;
            endcase
        end
        iseq_busy = 1'b0; autoref_ack = 1'b0; zq_ack = 1'b0;
`else
        // ---------------- no postponement: refresh goes out despite busy ----------------
        do_reset();
        cfg_trefi = CW'(10);
        cfg_en    = 1'b1;
        iseq_busy = 1'b1;
        for (int ed = 1; ed <= 21; ed++) begin
            step();
            if (ed == 10) chk("nopost_pre", {ref_debt, autoref_req}, 0);
            if (ed == 11) begin
                chk("nopost_req", autoref_req, 1);
                chk("nopost_debt", ref_debt, 1);
                chk("nopost_urgent", maint_urgent, 1);
            end
            if (ed == 21) begin
                chk("nopost_ovf", debt_ovf, 1);
                chk("nopost_debt_cap", ref_debt, 1);
            end
        end
        iseq_busy = 1'b0;
`endif

        // ---------------- periodic read with lock, then async reset ----------------
        do_reset();
        cfg_tprd = CW'(50);
        cfg_en   = 1'b1;
        for (int ed = 1; ed <= 155; ed++) begin
            pr_rd_lock = (ed >= 54) && (ed <= 109);
            step();
            case (ed)
                50: chk("prd_pre", pr_rd_req, 0);
                51, 52, 53: chk("prd_req", pr_rd_req, 1);
                54: chk("prd_lock_drop", pr_rd_req, 0);
                101, 115: chk("prd_dropped_tick", pr_rd_req, 0);
                151, 155: chk("prd_req_again", pr_rd_req, 1);
                default: ;
            endcase
        end
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", {ref_debt, maint_urgent, debt_ovf, autoref_req, zq_req, pr_rd_req}, 0);
        #3;
        rst = 1'b0;

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        m_debt = 0; m_ovf = 0; m_zq = 0; m_prd = 0; m_lock = 0;
        m_urg = 0; m_ar = 0; m_zr = 0; m_pr = 0;
        for (int i = 0; i < 3; i++) begin
            act_t[i] = 0; nt[i] = 0; P[i] = 0;
        end
        off = 3;
        e = 0;
        for (int c = 0; c < 5000; c++) begin
            if (off > 0) off--;
            else if ($urandom_range(0, 99) < 2) off = $urandom_range(1, 4);
            cfg_en = (off == 0);
            if (!cfg_en) begin
                for (int i = 0; i < 3; i++)
                    P[i] = ($urandom_range(0, 9) < 2) ? 0 : $urandom_range(1, 30);
                cfg_trefi = CW'(P[0]); cfg_tzqi = CW'(P[1]); cfg_tprd = CW'(P[2]);
            end
            if ($urandom_range(0, 99) < 5) iseq_busy = !iseq_busy;
            autoref_ack = (m_ar && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 49) == 0);
            zq_ack      = (m_zr && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 49) == 0);
            if (m_pr && $urandom_range(0, 3) == 0) pr_rd_lock = 1'b1;
            else if (pr_rd_lock && $urandom_range(0, 4) == 0) pr_rd_lock = 1'b0;
            else if ($urandom_range(0, 39) == 0) pr_rd_lock = 1'b1;

            // timers: load on the first enabled edge, then tick every P edges
            e++;
            for (int i = 0; i < 3; i++) begin
                tk[i] = 0;
                if (!cfg_en || P[i] == 0) act_t[i] = 0;
                else if (!act_t[i]) begin act_t[i] = 1; nt[i] = e + P[i]; end
                else if (e == nt[i]) begin tk[i] = 1; nt[i] = nt[i] + P[i]; end
            end
            if (!cfg_en) begin
                m_debt = 0; m_ovf = 0; m_zq = 0; m_prd = 0;
            end else begin
                ae = autoref_ack && (m_debt != 0);
                if (tk[0] && !ae) begin
                    if (m_debt == LIM) m_ovf = 1;
                    else m_debt = m_debt + 1;
                end else if (!tk[0] && ae) m_debt = m_debt - 1;
                if (tk[1]) m_zq = 1;
                else if (zq_ack) m_zq = 0;
                if (pr_rd_lock && !m_lock) m_prd = 0;
                else if (tk[2] && !pr_rd_lock) m_prd = 1;
            end
            m_lock = pr_rd_lock;
            m_urg  = (m_debt == LIM);
            m_ar   = (m_debt != 0) && (!iseq_busy || m_urg);
            m_zr   = m_zq && !iseq_busy && !m_urg;
            m_pr   = m_prd && !pr_rd_lock && !iseq_busy && !m_urg;

            step();
            chk("rand_cycle",
                {ref_debt, maint_urgent, debt_ovf, autoref_req, zq_req, pr_rd_req},
                {4'(m_debt), m_urg, m_ovf, m_ar, m_zr, m_pr});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
